// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with one 7-bit address, byte-wide write and read transfers
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       busy_o,
    output logic       nack_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_d_q, sda_d_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        byte_done_q, byte_done_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d;
    logic        busy_q, busy_d;
    logic        nack_q, nack_d;

    // Synchronisers reset to 1 so an idle bus produces no spurious START/STOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_d_q    <= scl_s;
            sda_d_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_q;
    assign scl_fall  = ~scl_s & scl_d_q;
    assign start_det = scl_s & scl_d_q & sda_d_q & ~sda_s;
    assign stop_det  = scl_s & scl_d_q & ~sda_d_q & sda_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 7'd0;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
            nack_q      <= nack_d;
        end
    end

    // byte_done marks a completed byte whose ACK slot starts at the next scl_fall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy_q;
        nack_d      = 1'b0;

        if (start_det) begin
            state_d     = ADDR;
            cnt_d       = 3'd7;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            byte_done_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            byte_done_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        if (cnt_q == 3'd0) begin
                            if (shift_q == SLAVE_ADDR) begin
                                busy_d      = 1'b1;
                                byte_done_d = 1'b1;
                                rw_d        = sda_s;
                            end else begin
                                state_d  = IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                        state_d     = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        cnt_d = 3'd7;
                        if (rw_q) begin
                            shift_d  = tx_data_i[6:0];
                            sda_oe_d = ~tx_data_i[7];
                            state_d  = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        if (cnt_q == 3'd0) begin
                            rx_data_d   = {shift_q, sda_s};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                        state_d     = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        state_d  = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = READ_ACK;
                        end else begin
                            cnt_d    = cnt_q - 3'd1;
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d    = 1'b1;
                            byte_done_d = 1'b1;
                        end else begin
                            nack_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        cnt_d       = 3'd7;
                        shift_d     = tx_data_i[6:0];
                        sda_oe_d    = ~tx_data_i[7];
                        state_d     = READ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_req_o   = tx_req_q;
    assign busy_o     = busy_q;
    assign nack_o     = nack_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave acting as an I2C bus master
module tb_i2c_slave;

    localparam int Q = 5;

    logic       clk;
    logic       rst_ni;
    logic       m_scl;
    logic       m_sda;
    logic       bus_sda;
    logic       sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic       busy_o;
    logic       nack_o;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;
    int nack_cnt = 0;
    int oe_cnt   = 0;
    logic [7:0] rx_log [0:15];

    assign bus_sda = m_sda & ~sda_oe_o;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scl_i      (m_scl),
        .sda_i      (bus_sda),
        .sda_oe_o   (sda_oe_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .tx_data_i  (tx_data_i),
        .tx_req_o   (tx_req_o),
        .busy_o     (busy_o),
        .nack_o     (nack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = rx_data_o;
            rx_cnt++;
        end
        if (tx_req_o) tx_cnt++;
        if (nack_o) nack_cnt++;
        if (sda_oe_o) oe_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic seen);
        m_sda = b;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        seen = bus_sda;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        tx_data_i = next_tx;
        send_bit(~mack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         rx0, tx0, nk0, oe0;

        rst_ni    = 1'b0;
        m_scl     = 1'b1;
        m_sda     = 1'b1;
        tx_data_i = 8'h00;
        repeat (4) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_sda_oe", {31'd0, sda_oe_o}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_pulses", {29'd0, rx_valid_o, tx_req_o, nack_o}, 32'd0);

        // two-byte write
        rx0 = rx_cnt;
        do_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd1);
        check("wr_busy", {31'd0, busy_o}, 32'd1);
        write_byte(8'h3C, ack);
        check("wr_b0_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hF1, ack);
        check("wr_b1_ack", {31'd0, ack}, 32'd1);
        do_stop();
        check("wr_rx_count", rx_cnt - rx0, 32'd2);
        check("wr_rx0", {24'd0, rx_log[rx0]}, 32'h3C);
        check("wr_rx1", {24'd0, rx_log[rx0+1]}, 32'hF1);
        check("wr_busy_after_stop", {31'd0, busy_o}, 32'd0);

        // read with ACK then NACK
        tx0 = tx_cnt;
        nk0 = nack_cnt;
        tx_data_i = 8'h5A;
        do_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b1, 8'hC3, d);
        check("rd_byte0", {24'd0, d}, 32'h5A);
        read_byte(1'b0, 8'h00, d);
        check("rd_byte1", {24'd0, d}, 32'hC3);
        check("rd_tx_req_count", tx_cnt - tx0, 32'd2);
        check("rd_nack_count", nack_cnt - nk0, 32'd1);
        check("rd_sda_released", {31'd0, sda_oe_o}, 32'd0);
        check("rd_busy_after_nack", {31'd0, busy_o}, 32'd0);
        do_stop();

        // address mismatch
        rx0 = rx_cnt;
        oe0 = oe_cnt;
        do_start();
        write_byte(8'hA2, ack);
        check("mm_no_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h55, ack);
        do_stop();
        check("mm_oe_cycles", oe_cnt - oe0, 32'd0);
        check("mm_rx_count", rx_cnt - rx0, 32'd0);
        check("mm_busy", {31'd0, busy_o}, 32'd0);

        // repeated START: write then read
        nk0 = nack_cnt;
        do_start();
        write_byte(8'hA0, ack);
        write_byte(8'h10, ack);
        check("rs_wr_ack", {31'd0, ack}, 32'd1);
        tx_data_i = 8'h99;
        do_start();
        write_byte(8'hA1, ack);
        check("rs_rd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b0, 8'h00, d);
        check("rs_rd_byte", {24'd0, d}, 32'h99);
        do_stop();
        check("rs_rx_data", {24'd0, rx_data_o}, 32'h10);
        check("rs_nack_count", nack_cnt - nk0, 32'd1);
        check("rs_idle", {30'd0, busy_o, sda_oe_o}, 32'd0);

        // STOP after 4 bits of a write byte, then a complete write
        rx0 = rx_cnt;
        do_start();
        write_byte(8'hA0, ack);
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        send_bit(1'b1, s);
        do_stop();
        check("ab_no_rx_valid", rx_cnt - rx0, 32'd0);
        check("ab_rx_data_held", {24'd0, rx_data_o}, 32'h10);
        do_start();
        write_byte(8'hA0, ack);
        write_byte(8'h7E, ack);
        check("ab_new_ack", {31'd0, ack}, 32'd1);
        do_stop();
        check("ab_rx_data", {24'd0, rx_data_o}, 32'h7E);
        check("ab_rx_count", rx_cnt - rx0, 32'd1);

        // reset while the target is driving a 0 data bit
        tx_data_i = 8'h5A;
        do_start();
        write_byte(8'hA1, ack);
        check("rst_driving_zero", {31'd0, sda_oe_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_release", {31'd0, sda_oe_o}, 32'd0);
        check("rst_outputs", {20'd0, rx_data_o, rx_valid_o, tx_req_o, busy_o, nack_o}, 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        rx0 = rx_cnt;
        do_start();
        write_byte(8'hA0, ack);
        check("rst_after_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h33, ack);
        do_stop();
        check("rst_after_rx_data", {24'd0, rx_data_o}, 32'h33);
        check("rst_after_rx_count", rx_cnt - rx0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the bus driven by i2c_master: one 7-bit address, byte-wide write and read transfers to local logic.
- SCL/SDA are oversampled on the system clock through synchronisers. START, STOP, repeated START, ACK and NACK are all decoded.
- SDA is open-drain: the block only pulls low via sda_oe_o. No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, own 7-bit bus address.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (minimum 2).

Ports:
- clk_i  in  1  system clock; ≥8x SCL frequency.
- rst_ni  in  1  asynchronous active-low reset.
- scl_i  in  1  bus SCL (async).
- sda_i  in  1  bus SDA sensed value (async).
- sda_oe_o  out  1  1 = pull SDA low, 0 = release.
- rx_data_o  out  8  last byte written by master.
- rx_valid_o  out  1  one-cycle pulse; rx_data_o valid.
- tx_data_i  in  8  byte to return on read.
- tx_req_o  out  1  one-cycle pulse; tx_data_i must be stable by next SCL fall.
- busy_o  out  1  high from addressed START to STOP/NACK/mismatch.
- nack_o  out  1  one-cycle pulse when master NACKs a read byte.

Behaviour:
- Reset values: sda_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_req_o=0, busy_o=0, nack_o=0, state=IDLE, bit counter=0. Synchroniser flops reset to 1 (idle bus).
- Event detection uses synced signals plus a one-cycle-delayed copy:
  - scl_rise, scl_fall: synced SCL edges.
  - START: synced SDA 1->0 while SCL=1.
  - STOP: synced SDA 0->1 while SCL=1.
- Input-to-event latency is SYNC_STAGES+1 cycles.
- Sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_oe_o changes only on scl_fall, except when forced to 0 (see STOP/START rules).
- Bit order is MSB first. A 3-bit counter counts bits 7..0.
- States and transitions:
  - IDLE: on START, go to ADDR with counter=7.
  - ADDR: shift 8 bits (addr[6:0], R/W). On the 8th scl_rise, compare addr with SLAVE_ADDR.
    - Match: busy_o=1. At the next scl_fall, sda_oe_o=1 and go to ADDR_ACK.
    - Mismatch: go to IDLE with sda_oe_o=0.
  - ADDR_ACK: at the scl_fall ending the ACK slot:
    - W: sda_oe_o=0, go to WRITE.
    - R: load shift register from tx_data_i, drive bit7 (sda_oe_o = ~bit), go to READ.
    - tx_req_o pulses on the scl_rise of the ACK slot for R.
  - WRITE: shift 8 bits.
    - On the 8th scl_rise: rx_data_o updated and rx_valid_o pulses in the same cycle.
    - At the next scl_fall: sda_oe_o=1, go to WRITE_ACK.
  - WRITE_ACK: at scl_fall, sda_oe_o=0, go to WRITE. Unlimited bytes.
  - READ: drive the next bit on each scl_fall. After the 8th bit's scl_fall, sda_oe_o=0 and go to READ_ACK.
  - READ_ACK: on scl_rise, sample master's response.
    - SDA=0 (ACK): tx_req_o pulses. At the next scl_fall, load tx_data_i and go to READ.
    - SDA=1 (NACK): nack_o pulses, busy_o=0, go to IDLE.
- STOP in any state: next cycle state=IDLE, sda_oe_o=0, busy_o=0.
- Repeated START in any state: sda_oe_o=0, state=ADDR, counter=7, busy_o=0 until re-match.
- Never drive SDA low during SCL high except in ACK/data slots already set up on the preceding scl_fall.
- rx_data_o holds its value until the next completed write byte. A partial byte aborted by START/STOP does not update it and does not pulse rx_valid_o.
- Address 0 (general call) is not recognised unless SLAVE_ADDR=0.
- Reset asserted mid-transfer: SDA is released immediately (asynchronously).

Test Plan:
- Write 2 bytes: START, 0xA0 (addr 0x50, W), 0x3C, 0xF1, STOP -> three ACKs (SDA low in slots 9/18/27); rx_valid_o pulses twice, rx_data_o=0x3C then 0xF1; busy_o falls after STOP.
- Read with ACK then NACK: START, 0xA1, tx_data_i=0x5A then 0xC3 -> bus sees 0x5A, 0xC3; tx_req_o pulses twice; nack_o pulses once; sda_oe_o=0 after the 2nd byte.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda_oe_o stays 0 throughout; no rx_valid_o; busy_o=0.
- Repeated START: write 0xA0, 0x10, then Sr, 0xA1, read 0x99 with NACK -> rx_data_o=0x10; read byte 0x99 on bus; state IDLE after STOP.
- Abort: STOP after 4 bits of a write byte, then new write 0xA0, 0x7E -> no rx_valid_o for the partial byte; rx_data_o=0x7E afterwards.
- Reset: assert rst_ni low during READ while driving a 0 bit -> sda_oe_o=0 in the same cycle; all outputs at reset values; next START is handled normally.
